seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the multiplexed 7-segment display drivers. It monitors the active-low anode and segment lines of an 8-digit time-multiplexed display. It reconstructs the hex value shown on each digit and flags frames, invalid glyphs and bus errors. It is used as an on-chip loopback checker behind display drivers and as a bench monitor.

---
 rtl/seg7_pkg.sv | 49 ++++
 rtl/seg7_glyph_decode.sv | 14 +
 rtl/seg7_scan_decoder.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: glyph patterns
// (lit segments, abcdefg order, a = MSB), anode count and glyph decode.
package seg7_pkg;

    localparam int NUM_ANODES = 8;

    localparam logic [6:0] GLYPH_0 = 7'h7E;
    localparam logic [6:0] GLYPH_1 = 7'h30;
    localparam logic [6:0] GLYPH_2 = 7'h6D;
    localparam logic [6:0] GLYPH_3 = 7'h79;
    localparam logic [6:0] GLYPH_4 = 7'h33;
    localparam logic [6:0] GLYPH_5 = 7'h5B;
    localparam logic [6:0] GLYPH_6 = 7'h5F;
    localparam logic [6:0] GLYPH_7 = 7'h70;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h7B;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h1F;
    localparam logic [6:0] GLYPH_C = 7'h4E;
    localparam logic [6:0] GLYPH_D = 7'h3D;
    localparam logic [6:0] GLYPH_E = 7'h4F;
    localparam logic [6:0] GLYPH_F = 7'h47;

    // Entry k holds the lit pattern of hex value k.
    localparam logic [15:0][6:0] GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
        GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
        GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    // Active-low segments in, {valid, blank, nibble} out.
    function automatic logic [5:0] glyph_decode(input logic [6:0] seg_n);
        logic [6:0] lit;
        logic [5:0] res;
        lit = ~seg_n;
        res = 6'b00_0000;
        if (lit == 7'h00) begin
            res = 6'b01_0000;
        end
        for (int k = 0; k < 16; k++) begin
            if (lit == GLYPHS[k]) begin
                res = {2'b10, 4'(k)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder.
// Ports: seg_n[6:0] active-low abcdefg in; valid, blank, nibble[3:0] out.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       valid,
    output logic       blank,
    output logic [3:0] nibble
);

    assign {valid, blank, nibble} = glyph_decode(seg_n);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 8-digit 7-segment bus and rebuilds digit values.
// Ports: clk, reset_n, seg_a..seg_g, anodes[7:0] in;
//        digits[31:0], digit_valid, blank, frame_done, error, active out.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int settle_cycles = 8,
    parameter int settle_width  = 4,
    parameter int timeout_width = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        seg_a,
    input  logic        seg_b,
    input  logic        seg_c,
    input  logic        seg_d,
    input  logic        seg_e,
    input  logic        seg_f,
    input  logic        seg_g,
    input  logic [7:0]  anodes,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic [7:0]  blank,
    output logic        frame_done,
    output logic        error,
    output logic        active
);

    localparam logic [settle_width-1:0] SETTLE_MAX =
        settle_width'(settle_cycles);
    localparam logic [timeout_width-1:0] TO_MAX = '1;

    logic [14:0] pins;
    logic [14:0] sync1_q, sync1_d;
    logic [14:0] sync2_q, sync2_d;
    logic [14:0] prev_q, prev_d;
    logic [settle_width-1:0]  settle_q, settle_d;
    logic [timeout_width-1:0] to_q, to_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  valid_q, valid_d;
    logic [7:0]  blank_q, blank_d;
    logic [7:0]  visited_q, visited_d;
    logic        frame_q, frame_d;
    logic        error_q, error_d;
    logic        fault_q, fault_d;
    logic        active_q, active_d;

    logic [7:0] an_low;
    logic [7:0] vis_next;
    logic [2:0] idx;
    logic       idle, onehot, fault, changed, capture, timed_out;
    logic       dec_valid, dec_blank;
    logic [3:0] dec_nibble;

    assign pins = {anodes, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

    seg7_glyph_decode u_glyph (
        .seg_n  (sync2_q[6:0]),
        .valid  (dec_valid),
        .blank  (dec_blank),
        .nibble (dec_nibble)
    );

    always_comb begin
        sync1_d = pins;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        an_low  = ~sync2_q[14:7];
        idle    = (an_low == 8'h00);
        onehot  = !idle && ((an_low & (an_low - 8'd1)) == 8'h00);
        fault   = !idle && !onehot;
        changed = (sync2_q != prev_q);

        idx = 3'd0;
        for (int i = 0; i < NUM_ANODES; i++) begin
            if (an_low[i]) begin
                idx = i[2:0];
            end
        end

        // Idle and fault hold the counter at 0 so a later one-hot
        // anode always starts a fresh settle period.
        if (changed || !onehot) begin
            settle_d = '0;
        end else if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + settle_width'(1);
        end else begin
            settle_d = settle_q;
        end

        capture = onehot && !changed && (settle_q == SETTLE_MAX - 1'b1);

        timed_out = (to_q == TO_MAX) && !capture;
        if (capture) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + timeout_width'(1);
        end else begin
            to_d = to_q;
        end

        digits_d  = digits_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        visited_d = visited_q;
        active_d  = active_q;
        frame_d   = 1'b0;
        vis_next  = visited_q | an_low;

        if (timed_out) begin
            active_d  = 1'b0;
            valid_d   = 8'h00;
            blank_d   = 8'h00;
            visited_d = 8'h00;
        end

        if (capture) begin
            digits_d[{idx, 2'b00} +: 4] = dec_nibble;
            valid_d[idx] = dec_valid;
            blank_d[idx] = dec_blank;
            active_d     = 1'b1;
            // The completing capture is consumed by this frame.
            if (vis_next == 8'hFF) begin
                frame_d   = 1'b1;
                visited_d = 8'h00;
            end else begin
                visited_d = vis_next;
            end
        end

        fault_d = fault;
        error_d = fault && !fault_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            prev_q    <= '1;
            settle_q  <= '0;
            to_q      <= '0;
            digits_q  <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            visited_q <= '0;
            frame_q   <= 1'b0;
            error_q   <= 1'b0;
            fault_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            settle_q  <= settle_d;
            to_q      <= to_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            visited_q <= visited_d;
            frame_q   <= frame_d;
            error_q   <= error_d;
            fault_q   <= fault_d;
            active_q  <= active_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign blank       = blank_q;
    assign frame_done  = frame_q;
    assign error       = error_q;
    assign active      = active_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed testbench for seg7_scan_decoder.
// Drives scan patterns and compares outputs against hand-computed values.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [7:0]  anodes = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic [7:0]  blank;
    logic        frame_done;
    logic        error;
    logic        active;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    int err_cnt = 0;
    int base;
    logic [31:0] fd_digits = '0;
    logic [7:0]  fd_valid = '0;

    // Lit patterns, abcdefg with a as MSB.
    localparam logic [6:0] L0 = 7'h7E;
    localparam logic [6:0] L1 = 7'h30;
    localparam logic [6:0] L2 = 7'h6D;
    localparam logic [6:0] L3 = 7'h79;
    localparam logic [6:0] L4 = 7'h33;
    localparam logic [6:0] L5 = 7'h5B;
    localparam logic [6:0] L6 = 7'h5F;
    localparam logic [6:0] L7 = 7'h70;
    localparam logic [6:0] L9 = 7'h7B;
    localparam logic [7:0][6:0] SCAN = {L7, L6, L5, L4, L3, L2, L1, L0};

    seg7_scan_decoder #(
        .settle_cycles (8),
        .settle_width  (4),
        .timeout_width (6)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_a       (seg[6]),
        .seg_b       (seg[5]),
        .seg_c       (seg[4]),
        .seg_d       (seg[3]),
        .seg_e       (seg[2]),
        .seg_f       (seg[1]),
        .seg_g       (seg[0]),
        .anodes      (anodes),
        .digits      (digits),
        .digit_valid (digit_valid),
        .blank       (blank),
        .frame_done  (frame_done),
        .error       (error),
        .active      (active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt++;
            fd_digits = digits;
            fd_valid  = digit_valid;
        end
        if (error) begin
            err_cnt++;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [7:0] an, input logic [6:0] lit);
        anodes = an;
        seg    = ~lit;
    endtask

    initial begin
        tick(2);
        chk("rst_digits", digits, 32'h0);
        chk("rst_valid", {24'h0, digit_valid}, 32'h0);
        chk("rst_blank", {24'h0, blank}, 32'h0);
        chk("rst_flags", {29'h0, frame_done, error, active}, 32'h0);
        reset_n = 1'b1;

        // Static digit "3" on digit 0.
        show(8'hFE, L3);
        tick(10);
        chk("static_early", {24'h0, digit_valid}, 32'h0);
        tick(1);
        chk("static_nib", {28'h0, digits[3:0]}, 32'h3);
        chk("static_valid", {24'h0, digit_valid}, 32'h01);
        chk("static_active", {31'h0, active}, 32'h1);
        chk("static_fd", fd_cnt, 0);
        tick(9);

        // Full scan, glyphs 0..7 on digits 0..7.
        fd_cnt = 0;
        for (int d = 0; d < 8; d++) begin
            show(~(8'd1 << d), SCAN[d]);
            tick(16);
        end
        chk("scan_digits", digits, 32'h76543210);
        chk("scan_valid", {24'h0, digit_valid}, 32'hFF);
        chk("scan_blank", {24'h0, blank}, 32'h0);
        chk("scan_fd_cnt", fd_cnt, 1);
        chk("scan_fd_digits", fd_digits, 32'h76543210);
        chk("scan_fd_valid", {24'h0, fd_valid}, 32'hFF);

        // Glitch: "1" too short to settle, then "7" on digit 2.
        show(8'hFB, L1);
        tick(5);
        show(8'hFB, L7);
        tick(10);
        chk("glitch_none", {28'h0, digits[11:8]}, 32'h2);
        tick(1);
        chk("glitch_cap", {28'h0, digits[11:8]}, 32'h7);
        tick(5);

        // Multiple anodes low.
        base = err_cnt;
        show(8'hFC, L7);
        tick(10);
        chk("fault_err1", err_cnt - base, 1);
        chk("fault_digits", digits, 32'h76543710);
        chk("fault_valid", {24'h0, digit_valid}, 32'hFF);
        chk("fault_blank", {24'h0, blank}, 32'h0);
        show(8'hFE, L7);
        tick(6);
        show(8'hFC, L7);
        tick(6);
        chk("fault_err2", err_cnt - base, 2);

        // Non-glyph pattern on digit 0, all-off on digit 1.
        show(8'hFE, 7'h04);
        tick(12);
        chk("odd_nib", {28'h0, digits[3:0]}, 32'h0);
        chk("odd_valid", {31'h0, digit_valid[0]}, 32'h0);
        chk("odd_blank", {31'h0, blank[0]}, 32'h0);
        show(8'hFD, 7'h00);
        tick(12);
        chk("off_blank", {24'h0, blank}, 32'h02);
        chk("off_valid", {24'h0, digit_valid}, 32'hFC);
        chk("off_nib", {28'h0, digits[7:4]}, 32'h0);

        // Inactivity timeout.
        show(8'hFF, 7'h00);
        tick(50);
        chk("to_before", {31'h0, active}, 32'h1);
        tick(20);
        chk("to_active", {31'h0, active}, 32'h0);
        chk("to_valid", {24'h0, digit_valid}, 32'h0);
        chk("to_blank", {24'h0, blank}, 32'h0);
        chk("to_digits", digits, 32'h76543700);

        // Capture, then asynchronous reset mid-scan.
        show(8'hF7, L5);
        tick(11);
        chk("pre_rst_nib", {28'h0, digits[15:12]}, 32'h5);
        chk("pre_rst_active", {31'h0, active}, 32'h1);
        show(8'hEF, L9);
        tick(5);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_digits", digits, 32'h0);
        chk("arst_valid", {24'h0, digit_valid}, 32'h0);
        chk("arst_active", {31'h0, active}, 32'h0);
        tick(3);
        reset_n = 1'b1;
        tick(10);
        chk("rel_early", {24'h0, digit_valid}, 32'h0);
        tick(1);
        chk("rel_valid", {24'h0, digit_valid}, 32'h10);
        chk("rel_digits", digits, 32'h00090000);
        chk("rel_active", {31'h0, active}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
